// File: rtl/mdu_seq.sv
// Iterative 32-iteration multiply / restoring-divide engine owning HI/LO; 34-cycle busy window, done one cycle after.
// Optional feature macro: MDU_EARLY_OUT_EN (zero operand skips the iteration loop).
module mdu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        dz_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        neg_q, neg_d, dneg_q, dneg_d;
    logic [64:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        dz_q, dz_d, done_q, done_d;

    // op[1] selects divide, op[0] selects unsigned
    logic        is_div, is_signed;
    logic [32:0] sum, rem_sh;
    logic [63:0] prod;
    logic [31:0] quo, rem, raw_a;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        dneg_d  = dneg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        sum     = '0;
        rem_sh  = '0;
        prod    = '0;
        quo     = '0;
        rem     = '0;
        raw_a   = '0;

        case (state_q)
            S_IDLE: begin
                if (mthi_i) hi_d = wdata_i;
                if (mtlo_i) lo_d = wdata_i;
                if (start_i) begin
                    op_d    = op_i;
                    a_d     = opa_i;
                    b_d     = opb_i;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                // -2^31 maps onto unsigned 0x80000000, which the datapath handles directly
                if (is_signed) begin
                    a_d = a_q[31] ? -a_q : a_q;
                    b_d = b_q[31] ? -b_q : b_q;
                end
                neg_d  = is_signed & (a_q[31] ^ b_q[31]);
                dneg_d = is_signed & a_q[31];
                acc_d  = is_div ? {33'd0, a_d} : {33'd0, b_d};
                cnt_d  = 5'd0;
                state_d = S_CALC;
`ifdef MDU_EARLY_OUT_EN
                if (a_q == 32'd0 || b_q == 32'd0) state_d = S_FIX;
`endif
            end
            S_CALC: begin
                if (!is_div) begin
                    // multiplier sits in the low half and shifts out as the product shifts in
                    sum   = acc_q[64:32] + (acc_q[0] ? {1'b0, a_q} : 33'd0);
                    acc_d = {1'b0, sum, acc_q[31:1]};
                end else begin
                    rem_sh = acc_q[63:31];
                    if (rem_sh >= {1'b0, b_q})
                        acc_d = {rem_sh - {1'b0, b_q}, acc_q[30:0], 1'b1};
                    else
                        acc_d = {rem_sh, acc_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div) begin
                    prod = acc_q[63:0];
                    if (neg_q) prod = -prod;
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                    dz_d = 1'b0;
                end else if (b_q == 32'd0) begin
                    raw_a = dneg_q ? -a_q : a_q;
                    hi_d  = raw_a;
                    lo_d  = 32'hFFFF_FFFF;
                    dz_d  = 1'b1;
                end else begin
                    quo  = neg_q  ? -acc_q[31:0]  : acc_q[31:0];
                    rem  = dneg_q ? -acc_q[63:32] : acc_q[63:32];
                    hi_d = rem;
                    lo_d = quo;
                    dz_d = 1'b0;
                end
`ifdef MDU_EARLY_OUT_EN
                if ((a_q == 32'd0 || b_q == 32'd0) && !(is_div && b_q == 32'd0)) begin
                    hi_d = 32'd0;
                    lo_d = 32'd0;
                    dz_d = 1'b0;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            neg_q   <= 1'b0;
            dneg_q  <= 1'b0;
            acc_q   <= 65'd0;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            dneg_q  <= dneg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign dz_o   = dz_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: vector table plus hand sequences for mthi/mtlo, busy-time requests and reset abort.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa, opb;
    logic        mthi, mtlo;
    logic [31:0] wdata;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    mdu_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .op_i    (op),
        .opa_i   (opa),
        .opb_i   (opb),
        .mthi_i  (mthi),
        .mtlo_i  (mtlo),
        .wdata_i (wdata),
        .busy_o  (busy),
        .done_o  (done),
        .dz_o    (dz),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drives start for one cycle; returns at the negedge after the sampling edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles (first already elapsed inside issue), bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        return (a == 32'd0 || b == 32'd0) ? 2 : 34;
`else
        return (a == b) ? 34 : 34;
`endif
    endfunction

    initial begin
        int n;
        int seen_done;

        vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4] = '{2'b11, 32'd100,       32'd0,          32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{2'b01, 32'd2,         32'd3,          32'h0000_0000, 32'h0000_0006, 1'b0};
        vecs[6] = '{2'b11, 32'd100,       32'd7,          32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[7] = '{2'b10, 32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[9] = '{2'b10, 32'hFFFF_FFF8, 32'd0,          32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};

        rst = 1'b1; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_dz",   {31'd0, dz},   32'd0);
        chk("reset_hi",   hi, 32'd0);
        chk("reset_lo",   lo, 32'd0);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_idle(n);
            chk($sformatf("v%0d_busy_cycles", i), n, exp_lat(vecs[i].a, vecs[i].b));
            chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            chk($sformatf("v%0d_dz", i), {31'd0, dz}, {31'd0, vecs[i].dz});
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // mtlo then mthi in IDLE take effect at the next edge
        @(negedge clk);
        mtlo = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'h1234_5678);
        chk("mtlo_hi_kept", hi, 32'hFFFF_FFF8);
        mthi = 1'b1; wdata = 32'h0BAD_F00D;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_hi", hi, 32'h0BAD_F00D);

        // mthi and a second start during busy are ignored
        issue(2'b01, 32'd2, 32'd3);
        repeat (5) @(negedge clk);
        mthi = 1'b1; wdata = 32'hAAAA_AAAA; start = 1'b1; op = 2'b11; opa = 32'd9; opb = 32'd0;
        @(negedge clk);
        mthi = 1'b0; start = 1'b0;
        chk("busy_mthi_ignored", hi, 32'h0BAD_F00D);
        wait_idle(n);
        chk("busy_ign_cycles", n, 32'd34 - 32'd6);
        chk("busy_ign_hi", hi, 32'd0);
        chk("busy_ign_lo", lo, 32'd6);
        chk("busy_ign_dz", {31'd0, dz}, 32'd0);
        @(negedge clk);
        chk("busy_ign_no_queue", {31'd0, busy}, 32'd0);

        // mthi accepted together with start, then overwritten in FIX
        @(negedge clk);
        mthi = 1'b1; wdata = 32'h5555_5555; start = 1'b1; op = 2'b01; opa = 32'd4; opb = 32'd4;
        @(negedge clk);
        mthi = 1'b0; start = 1'b0;
        chk("mthi_with_start_hi", hi, 32'h5555_5555);
        wait_idle(n);
        chk("mthi_with_start_final_hi", hi, 32'd0);
        chk("mthi_with_start_final_lo", lo, 32'd16);

        // reset mid-divide aborts with no done
        @(negedge clk);
        mtlo = 1'b1; mthi = 1'b1; wdata = 32'hCAFE_0001;
        @(negedge clk);
        mtlo = 1'b0; mthi = 1'b0;
        issue(2'b11, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        chk("abort_no_done", seen_done, 32'd0);

        issue(2'b01, 32'd5, 32'd5);
        wait_idle(n);
        chk("post_reset_cycles", n, 32'd34);
        chk("post_reset_lo", lo, 32'd25);
        chk("post_reset_hi", hi, 32'd0);
        chk("post_reset_done", {31'd0, done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative multiply/divide sequencer for the multi-cycle MIPS core. It implements `mult`, `multu`, `div` and `divu` as a shift-add / restoring-divide engine over 32 iterations and owns the architectural HI/LO registers. It also services `mthi`/`mtlo` writes. The main control FSM issues a one-cycle `start`, waits while `busy` is high, and reads `hi`/`lo` for `mfhi`/`mflo`.

## Interface
Parameters:
- none; the data width is fixed at 32 and the iteration count at 32.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  one-cycle operation request; sampled only in IDLE.
- `op`  in  2  operation select, sampled with `start`:
  - 00 = `mult`, 01 = `multu`, 10 = `div`, 11 = `divu`.
- `opa`  in  32  rs value (multiplicand or dividend); sampled with `start`.
- `opb`  in  32  rt value (multiplier or divisor); sampled with `start`.
- `mthi`  in  1  write `wdata` to HI.
- `mtlo`  in  1  write `wdata` to LO.
- `wdata`  in  32  data for `mthi`/`mtlo`.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  registered one-cycle pulse on the cycle after HI/LO are updated.
- `dz`  out  1  divide-by-zero flag for the last completed `div`/`divu`.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, PREP, CALC, FIX.
- IDLE: if `start`, latch `op`, `opa`, `opb`, go to PREP. Otherwise stay.
- PREP:
  - Signed ops: take magnitudes of the operands; record result sign (a^b) and dividend sign.
  - Clear the 64-bit accumulator and the 5-bit counter.
  - Go to CALC.
- CALC, one iteration per cycle; after iteration 31 (counter wraps to 0) go to FIX.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper 33 bits; then shift the accumulator right by 1.
  - Divide: shift {rem, quo} left by 1; if rem >= divisor, subtract it and set the quotient LSB.
- FIX: write HI/LO, set/clear `dz`, go to IDLE.
  - Multiply: {HI,LO} = product. For `mult` with negative sign, the 64-bit two's complement of the product.
  - Divide: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; it is negated if the result sign is 1.
  - Signed remainder takes the sign of the dividend.
  - Overflow case −2^31 / −1 gives LO = 0x80000000, HI = 0.
  - Divide by zero (`opb` == 0, signed or unsigned): HI = `opa`, LO = 0xFFFFFFFF, `dz` = 1.
  - `dz` is cleared by any completed operation without a zero divisor, including multiplies.
- `mthi`/`mtlo`:
  - Accepted only in IDLE; the register is written at the next edge.
  - Ignored while `busy`.
  - If asserted together with `start` in IDLE, both are accepted. HI/LO take `wdata` now and are overwritten in FIX.
- `start` while `busy` is ignored; no queuing.
- Arithmetic: the accumulator upper half is 33 bits wide (carry bit). The magnitude of −2^31 is represented as unsigned 0x80000000.

## Timing
- Edge E0 samples `start` in IDLE.
- E1: PREP -> CALC.
- E2..E33: 32 iterations.
- E33: CALC -> FIX.
- E34: HI/LO/`dz` written, state -> IDLE.
- `busy` is high from after E0 until E34; it is 1 for 34 cycles.
- `done` is high for the single cycle following E34, concurrent with `busy` = 0.
- A new `start` is accepted at E35, or at E34+1 while `done` is high.
- `hi`/`lo` are direct register outputs, stable except at the write edges.
- Reset values:
  - state IDLE, `busy` 0, `done` 0, `dz` 0.
  - `hi` and `lo` 0x00000000.
  - Counter and accumulator 0.
- Reset mid-operation aborts immediately: no `done`, HI/LO = 0.

## Configuration
- `MDU_EARLY_OUT_EN` defined:
  - In PREP, if `opa` == 0 or `opb` == 0, skip CALC and go directly to FIX.
  - FIX then writes HI = LO = 0, except for a zero divisor, which keeps the divide-by-zero rule above.
  - Latency: HI/LO written at E2, `done` in the cycle after E2.
- Not defined: every operation takes the full 34-cycle path regardless of operand values.

## Test plan
- `mult`, opa = 0xFFFFFFFD (−3), opb = 7 -> at E34 HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; `done` pulse one cycle; `busy` high exactly 34 cycles.
- `multu`, opa = opb = 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001; `dz` = 0.
- `div`, opa = 0xFFFFFFF9 (−7), opb = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; `div` 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- `divu`, opa = 100, opb = 0 -> HI = 0x00000064, LO = 0xFFFFFFFF, `dz` = 1. A following `multu` 2*3 clears `dz`, HI = 0, LO = 6.
- In IDLE, `mtlo` with wdata = 0x12345678 -> LO = 0x12345678 next cycle. During `busy`, `mthi` with 0xAAAAAAAA and a second `start` are both ignored; the result is unchanged.
- `rst` asserted at cycle 10 of a `divu` -> `busy` = 0, `hi` = `lo` = 0, no `done`. A fresh `multu` 5*5 afterwards gives LO = 25 at E34.
